// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// bsg_manycore_link_to_axil_pkg: shared constants and types for the host-to-manycore link path
package bsg_manycore_link_to_axil_pkg;
  localparam int mcl_fifo_width_gp = 128;
  localparam int host_req_els_gp = 2;
  typedef enum logic {idle_s, lock_s} host_req_state_e;
endpackage

// File: rtl/bsg_mcl_rr_pick.sv
// bsg_mcl_rr_pick: rotate-priority picker, first request above last_i wins, wrapping
module bsg_mcl_rr_pick #(
  parameter int els_p = 2,
  parameter int lg_els_p = 1
) (
  input  logic [els_p-1:0]    req_i,
  input  logic [lg_els_p-1:0] last_i,
  output logic [els_p-1:0]    grant_oh_o,
  output logic [lg_els_p-1:0] idx_o,
  output logic                any_o
);
  always_comb begin
    grant_oh_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= els_p; k++) begin
      for (int j = 0; j < els_p; j++) begin
        if (!any_o && req_i[j] && j == (int'(last_i) + k) % els_p) begin
          any_o = 1'b1;
          idx_o = lg_els_p'(j);
          grant_oh_o[j] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/bsg_mcl_host_req_sched.sv
// bsg_mcl_host_req_sched: packet-atomic round-robin scheduler for the host request stream with credit throttling
module bsg_mcl_host_req_sched
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter int num_req_p = host_req_els_gp,
  parameter int beats_per_pkt_p = mcl_fifo_width_gp / 32,
  parameter int max_inflight_p = 4,
  localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int beat_w_lp = (beats_per_pkt_p > 1) ? $clog2(beats_per_pkt_p) : 1,
  localparam int inflight_w_lp = $clog2(max_inflight_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [num_req_p-1:0]       req_v_i,
  input  logic [num_req_p-1:0][31:0] req_data_i,
  output logic [num_req_p-1:0]       req_ready_o,
  output logic                       v_o,
  output logic [31:0]                data_o,
  input  logic                       ready_i,
  input  logic [31:0]                out_credits_i,
  input  logic                       pkt_sent_i,
  output logic [lg_req_lp-1:0]       grant_id_o,
  output logic                       busy_o
);
  host_req_state_e state_q, state_d;
  logic [beat_w_lp-1:0] beat_q, beat_d;
  logic [inflight_w_lp-1:0] inflight_q, inflight_d;
  logic [lg_req_lp-1:0] grant_q, grant_d, last_q, last_d, pick_idx;
  logic [num_req_p-1:0] sel_q, sel_d, pick_oh;
  logic pick_any, lock, hs, last_beat, eligible, start, dec;

  bsg_mcl_rr_pick #(.els_p(num_req_p), .lg_els_p(lg_req_lp)) pick (
    .req_i(req_v_i),
    .last_i(last_q),
    .grant_oh_o(pick_oh),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  always_comb begin
    lock = state_q == lock_s;
    v_o = lock & |(sel_q & req_v_i);
    data_o = lock ? req_data_i[grant_q] : '0;
    req_ready_o = lock ? sel_q & {num_req_p{ready_i}} : '0;
    busy_o = lock;
    grant_id_o = grant_q;
    hs = v_o & ready_i;
    last_beat = hs && beat_q == beat_w_lp'(beats_per_pkt_p - 1);
    eligible = out_credits_i > 32'(inflight_q) && inflight_q < inflight_w_lp'(max_inflight_p);
    start = !lock && eligible && pick_any;
    dec = pkt_sent_i && inflight_q != '0;
    state_d = start ? lock_s : last_beat ? idle_s : state_q;
    beat_d = last_beat ? '0 : hs ? beat_q + 1'b1 : beat_q;
    inflight_d = inflight_q + inflight_w_lp'(last_beat) - inflight_w_lp'(dec);
    grant_d = start ? pick_idx : grant_q;
    sel_d = start ? pick_oh : sel_q;
    last_d = last_beat ? grant_q : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= idle_s;
      beat_q <= '0;
      inflight_q <= '0;
      grant_q <= '0;
      sel_q <= num_req_p'(1);
      last_q <= lg_req_lp'(num_req_p - 1);
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      inflight_q <= inflight_d;
      grant_q <= grant_d;
      sel_q <= sel_d;
      last_q <= last_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (reset_i) !(pkt_sent_i && inflight_q == '0));
endmodule

// File: tb/tb_bsg_mcl_host_req_sched.sv
// tb_bsg_mcl_host_req_sched: directed bench with a packet-level reference model checked every cycle
module tb_bsg_mcl_host_req_sched;
  localparam int N = 2;
  localparam int BPP = 4;
  localparam int MAXI = 4;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [N-1:0] req_v = '0;
  logic [N-1:0][31:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic v_o;
  logic [31:0] data_o;
  logic ready = 1'b0;
  logic [31:0] credits = '0;
  logic pkt_sent = 1'b0;
  logic [0:0] grant_id;
  logic busy;
  int vectors = 0;
  int errors = 0;
  int owner = -1, nbeats = 0, outstanding = 0, next_pri = 0, gid = 0;
  int sent, done, cyc = 0, hs_total = 0, dropped = 0;
  bit chk_en = 1'b0;
  bit prev_busy = 1'b0;
  bit exp_v;
  logic [N-1:0] exp_rdy;
  logic [31:0] exp_d;
  int log_q[$];

  bsg_mcl_host_req_sched #(.num_req_p(N), .beats_per_pkt_p(BPP), .max_inflight_p(MAXI)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .req_v_i(req_v),
    .req_data_i(req_data),
    .req_ready_o(req_ready),
    .v_o(v_o),
    .data_o(data_o),
    .ready_i(ready),
    .out_credits_i(credits),
    .pkt_sent_i(pkt_sent),
    .grant_id_o(grant_id),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit vbit(input logic [N-1:0] v, input int i);
    bit r = 1'b0;
    for (int k = 0; k < N; k++) if (k == i) r = v[k];
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset_i) begin
      owner = -1;
      nbeats = 0;
      outstanding = 0;
      next_pri = 0;
      gid = 0;
      chk_en = 1'b1;
    end else begin
      sent = (pkt_sent && outstanding > 0) ? 1 : 0;
      done = 0;
      if (owner < 0) begin
        if (longint'(credits) > longint'(outstanding) && outstanding < MAXI)
          for (int i = 0; i < N; i++)
            if (owner < 0 && vbit(req_v, (next_pri + i) % N)) begin
              owner = (next_pri + i) % N;
              gid = owner;
              nbeats = 0;
            end
      end else if (vbit(req_v, owner) && ready) begin
        nbeats++;
        if (nbeats == BPP) begin
          done = 1;
          next_pri = (owner + 1) % N;
          owner = -1;
        end
      end
      outstanding = outstanding + done - sent;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = 1'b0;
      exp_rdy = '0;
      exp_d = '0;
      for (int k = 0; k < N; k++)
        if (k == owner) begin
          exp_v = req_v[k];
          exp_rdy[k] = ready;
          exp_d = req_data[k];
        end
      chk("busy", 32'(busy), 32'(owner >= 0));
      chk("v_o", 32'(v_o), 32'(exp_v));
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("grant_id", 32'(grant_id), gid);
      if (exp_v) chk("data_o", data_o, exp_d);
      if (!reset_i) begin
        if (v_o && ready) hs_total++;
        if (busy && !prev_busy) log_q.push_back(int'(grant_id));
      end
      prev_busy = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int r = 0; r < N; r++) req_data[r] = {4'(r + 1), 28'(cyc)};
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step(2);
    reset_i = 1'b0;
    hs_total = 0;
    log_q.delete();
  endtask

  task automatic pulse_sent();
    pkt_sent = 1'b1;
    step(1);
    pkt_sent = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_v", 32'(v_o), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_gid", 32'(grant_id), 0);
    credits = 32'd8;
    ready = 1'b1;
    req_v = 2'b01;
    step(1);
    chk("first_beat_busy", 32'(busy), 1);
    chk("first_beat_v", 32'(v_o), 1);
    step(14);
    chk("single_hs", hs_total, 12);
    chk("single_pkts", log_q.size(), 3);
    credits = 32'd3;
    step(6);
    chk("credit_block_pkts", log_q.size(), 3);
    chk("credit_block_busy", 32'(busy), 0);
    pulse_sent();
    step(6);
    chk("credit_release_pkts", log_q.size(), 4);
    chk("credit_release_hs", hs_total, 16);
    chk("credit_reblock_busy", 32'(busy), 0);
    req_v = '0;
    repeat (3) pulse_sent();
    step(1);
    do_reset();
    credits = 32'd32;
    req_v = 2'b11;
    step(20);
    chk("rr_hs", hs_total, 16);
    chk("rr_pkts", log_q.size(), 4);
    chk("rr_g0", log_q[0], 0);
    chk("rr_g1", log_q[1], 1);
    chk("rr_g2", log_q[2], 0);
    chk("rr_g3", log_q[3], 1);
    step(6);
    chk("maxinf_pkts", log_q.size(), 4);
    chk("maxinf_busy", 32'(busy), 0);
    pulse_sent();
    step(4);
    pkt_sent = 1'b1;
    step(1);
    pkt_sent = 1'b0;
    step(1);
    chk("coinc_busy", 32'(busy), 1);
    chk("coinc_gid", 32'(grant_id), 1);
    step(4);
    chk("coinc_pkts", log_q.size(), 6);
    chk("coinc_hs", hs_total, 24);
    req_v = '0;
    do_reset();
    credits = 32'd32;
    req_v = 2'b11;
    for (int c = 0; c < 60; c++) begin
      ready = 1'($urandom_range(0, 1));
      if (hs_total == 2 && dropped < 4) begin
        req_v[0] = 1'b0;
        dropped++;
      end else req_v[0] = 1'b1;
      step(1);
    end
    chk("drop_cycles", dropped, 4);
    chk("drop_pkts_ge2", 32'(log_q.size() >= 2), 1);
    chk("drop_g0", log_q[0], 0);
    chk("drop_g1", log_q[1], 1);
    req_v = '0;
    ready = 1'b1;
    do_reset();
    req_v = 2'b01;
    step(5);
    req_v = 2'b10;
    step(2);
    chk("partial_gid", 32'(grant_id), 1);
    chk("partial_busy", 32'(busy), 1);
    reset_i = 1'b1;
    req_v = 2'b11;
    credits = 32'd1;
    step(1);
    chk("midrst_v", 32'(v_o), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_gid", 32'(grant_id), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    reset_i = 1'b0;
    step(1);
    chk("postrst_busy", 32'(busy), 1);
    chk("postrst_gid", 32'(grant_id), 0);
    step(6);
    chk("postrst_block", 32'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
